// File: rtl/cmp_test_sequencer_if.sv
// Bundles the sequencer's control, response and result signals between the
// fault-simulation bench (master) and the test sequencer (slave).
interface cmp_test_sequencer_if #(
  parameter int WIDTH = 2
);
  logic             start;
  logic             abort;
  logic             cut_resp;
  logic             gold_resp;
  logic [WIDTH-1:0] pat_out;
  logic             pat_valid;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   fail_cnt;
  logic             first_fail_valid;
  logic [WIDTH-1:0] first_fail_pat;

  modport master (
    output start, abort, cut_resp, gold_resp,
    input  pat_out, pat_valid, busy, done, fail_cnt, first_fail_valid, first_fail_pat
  );

  modport slave (
    input  start, abort, cut_resp, gold_resp,
    output pat_out, pat_valid, busy, done, fail_cnt, first_fail_valid, first_fail_pat
  );
endinterface

// File: rtl/cmp_test_sequencer.sv
// Steps a combinational comparator through every input pattern, waits a fixed
// settle time per pattern and tallies mismatches against a golden response.
module cmp_test_sequencer #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_test_sequencer_if.slave  bus
);

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] PAT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH:0]   fail_q, fail_d;
  logic             ffv_q, ffv_d;
  logic [WIDTH-1:0] ffp_q, ffp_d;

  // NOTE: every signal gets its hold value before the case, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pat_d         = pat_q;
    fail_d        = fail_q;
    ffv_d         = ffv_q;
    ffp_d         = ffp_q;
    bus.busy      = 1'b0;
    bus.pat_valid = 1'b0;
    bus.done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffp_d   = '0;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        bus.busy      = 1'b1;
        bus.pat_valid = 1'b1;
        cnt_d         = cnt_q + CNT_W'(1);
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        bus.busy      = 1'b1;
        bus.pat_valid = 1'b1;
        // An abort here drops this cycle's comparison; partial results hold.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          if (bus.cut_resp != bus.gold_resp) begin
            fail_d = fail_q + (WIDTH+1)'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffp_d = pat_q;
            end
          end
          if (pat_q == PAT_LAST) begin
            state_d = S_DONE;
          end else begin
            pat_d   = pat_q + WIDTH'(1);
            cnt_d   = '0;
            state_d = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffp_q   <= ffp_d;
    end
  end

  assign bus.pat_out          = pat_q;
  assign bus.fail_cnt         = fail_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_pat   = ffp_q;

endmodule

// File: tb/tb_cmp_test_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3) drive an emulated
// a>=b comparator with selectable stuck-at faults.
module tb_cmp_test_sequencer;

  typedef struct {
    string name;
    int    done_cnt;
    int    done_pos;
    int    len;
    int    fail_cnt;
    int    ffv;
    int    ffp;
    int    pat;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   mode1, mode3;  // 0 fault-free, 1 stuck-at-0, 2 stuck-at-1
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  cmp_test_sequencer_if #(.WIDTH(2)) bus1 ();
  cmp_test_sequencer_if #(.WIDTH(2)) bus3 ();

  cmp_test_sequencer #(.WIDTH(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  cmp_test_sequencer #(.WIDTH(2), .SETTLE(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  // Comparator under test: pattern {a,b}, golden response a >= b.
  assign bus1.gold_resp = (bus1.pat_out[1] >= bus1.pat_out[0]);
  assign bus1.cut_resp  = (mode1 == 0) ? bus1.gold_resp : (mode1 == 2);
  assign bus3.gold_resp = (bus3.pat_out[1] >= bus3.pat_out[0]);
  assign bus3.cut_resp  = (mode3 == 0) ? bus3.gold_resp : (mode3 == 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input int done_cnt, input int done_pos, input int len,
                         input logic [2:0] fc, input logic ffv, input logic [1:0] ffp,
                         input logic [1:0] pat, input logic pv);
    check({e.name, " done pulses"}, done_cnt, e.done_cnt);
    check({e.name, " done cycle"}, done_pos, e.done_pos);
    check({e.name, " busy cycles"}, len, e.len);
    check({e.name, " fail_cnt"}, {29'd0, fc}, e.fail_cnt);
    check({e.name, " first_fail_valid"}, {31'd0, ffv}, e.ffv);
    check({e.name, " first_fail_pat"}, {30'd0, ffp}, e.ffp);
    check({e.name, " pat_out"}, {30'd0, pat}, e.pat);
    check({e.name, " pat_valid idle"}, {31'd0, pv}, 0);
  endtask

  // Monitors: one scoreboard entry is retired each time busy falls.
  int len1 = 0, dcnt1 = 0, dpos1 = 0;
  logic busy1_prev = 1'b0;
  always @(negedge clk) begin
    if (bus1.busy) begin
      len1++;
      if (bus1.done) begin
        dcnt1++;
        dpos1 = len1;
      end
    end
    if (busy1_prev && !bus1.busy) begin
      if (q1.size() == 0) check("dut1 unexpected run end", 1, 0);
      else compare(q1.pop_front(), dcnt1, dpos1, len1, bus1.fail_cnt, bus1.first_fail_valid,
                   bus1.first_fail_pat, bus1.pat_out, bus1.pat_valid);
      len1 = 0; dcnt1 = 0; dpos1 = 0;
    end
    busy1_prev = bus1.busy;
  end

  int len3 = 0, dcnt3 = 0, dpos3 = 0, hold3 = 0;
  logic [1:0] last_pat3 = '0;
  logic busy3_prev = 1'b0;
  always @(negedge clk) begin
    if (bus3.busy) begin
      len3++;
      if (bus3.done) begin
        dcnt3++;
        dpos3 = len3;
      end
    end
    // Each pattern must stay on pat_out for SETTLE+1 = 4 cycles.
    if (bus3.pat_valid) begin
      if (hold3 > 0 && bus3.pat_out == last_pat3) hold3++;
      else begin
        if (hold3 > 0) check("dut3 pattern hold", hold3, 4);
        hold3 = 1;
        last_pat3 = bus3.pat_out;
      end
    end else if (hold3 > 0) begin
      check("dut3 pattern hold", hold3, 4);
      hold3 = 0;
    end
    if (busy3_prev && !bus3.busy) begin
      if (q3.size() == 0) check("dut3 unexpected run end", 1, 0);
      else compare(q3.pop_front(), dcnt3, dpos3, len3, bus3.fail_cnt, bus3.first_fail_valid,
                   bus3.first_fail_pat, bus3.pat_out, bus3.pat_valid);
      len3 = 0; dcnt3 = 0; dpos3 = 0;
    end
    busy3_prev = bus3.busy;
  end

  task automatic start1();
    @(negedge clk) bus1.start = 1'b1;
    @(negedge clk) bus1.start = 1'b0;
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    while (bus1.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus1.busy) check("dut1 run timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_idle3(input int budget);
    int n = 0;
    while (bus3.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus3.busy) check("dut3 run timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    mode1 = 0; mode3 = 0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    bus3.start = 1'b0; bus3.abort = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    check("reset pat_out", {30'd0, bus1.pat_out}, 0);
    check("reset pat_valid", {31'd0, bus1.pat_valid}, 0);
    check("reset busy", {31'd0, bus1.busy}, 0);
    check("reset done", {31'd0, bus1.done}, 0);
    check("reset fail_cnt", {29'd0, bus1.fail_cnt}, 0);
    check("reset first_fail_valid", {31'd0, bus1.first_fail_valid}, 0);
    check("reset first_fail_pat", {30'd0, bus1.first_fail_pat}, 0);
    check("reset dut3 busy", {31'd0, bus3.busy}, 0);

    // Fault-free: 4 patterns x 2 cycles + DONE, done in the 9th busy cycle.
    mode1 = 0;
    q1.push_back('{"fault-free", 1, 9, 9, 0, 0, 0, 3});
    start1();
    wait_idle1(50);

    // Stuck-at-0 fails patterns 00, 10, 11.
    mode1 = 1;
    q1.push_back('{"stuck-at-0", 1, 9, 9, 3, 1, 0, 3});
    start1();
    wait_idle1(50);

    // Stuck-at-1 fails only pattern 01; a clean rerun clears the results.
    mode1 = 2;
    q1.push_back('{"stuck-at-1", 1, 9, 9, 1, 1, 1, 3});
    start1();
    wait_idle1(50);
    mode1 = 0;
    q1.push_back('{"clean rerun", 1, 9, 9, 0, 0, 0, 3});
    start1();
    wait_idle1(50);

    // Abort in the SAMPLE cycle of pattern 10: that comparison is dropped.
    mode1 = 1;
    q1.push_back('{"abort", 0, 0, 6, 1, 1, 0, 2});
    start1();
    repeat (5) @(negedge clk);
    check("abort target pattern", {30'd0, bus1.pat_out}, 2);
    bus1.abort = 1'b1;
    @(negedge clk) bus1.abort = 1'b0;
    @(negedge clk);

    // Start coincident with abort in IDLE is suppressed.
    bus1.start = 1'b1; bus1.abort = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.abort = 1'b0;
    check("start+abort busy", {31'd0, bus1.busy}, 0);
    check("start+abort fail_cnt held", {29'd0, bus1.fail_cnt}, 1);
    check("start+abort pat_out held", {30'd0, bus1.pat_out}, 2);

    // SETTLE=3: 4 cycles per pattern, done in the 17th busy cycle; a stray
    // start mid-run must not disturb the sequence.
    mode3 = 0;
    q3.push_back('{"settle3", 1, 17, 17, 0, 0, 0, 3});
    @(negedge clk) bus3.start = 1'b1;
    @(negedge clk) bus3.start = 1'b0;
    repeat (6) @(negedge clk);
    bus3.start = 1'b1;
    @(negedge clk) bus3.start = 1'b0;
    wait_idle3(100);

    // Reset mid-run after pattern 00 has already been counted as a failure.
    mode1 = 1;
    q1.push_back('{"mid-run reset", 0, 0, 3, 0, 0, 0, 0});
    start1();
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk) rst1 = 1'b0;
    check("post-reset busy", {31'd0, bus1.busy}, 0);
    check("post-reset fail_cnt", {29'd0, bus1.fail_cnt}, 0);
    @(negedge clk);
    mode1 = 0;
    q1.push_back('{"after reset", 1, 9, 9, 0, 0, 0, 3});
    start1();
    wait_idle1(50);

    repeat (2) @(negedge clk);
    check("dut1 scoreboard drained", q1.size(), 0);
    check("dut3 scoreboard drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
